box_motion_ctrl: RTL
====================

// Module: box_motion_ctrl
// PURPOSE
//  Frame-synchronous position generator for the box overlay. Sits upstream of the box renderer.
//  Watches the vsync output of the VGA sync generator and, once per frame, moves a box origin
//  (box_x, box_y) across the 640x480 raster, bouncing off the edges.
//  The box renderer consumes box_x/box_y.
//  Updates happen only at vsync assertion, so a frame never tears.
// PARAMETERS
//  H_RES            640  active pixels per line
//  V_RES            480  active lines per frame
//  BOX_W            64   box width in pixels; X_MAX = H_RES-BOX_W
//  BOX_H            48   box height in lines; Y_MAX = V_RES-BOX_H
//  X_INIT           0    reset x origin, 0..X_MAX
//  Y_INIT           0    reset y origin, 0..Y_MAX
//  STEP_W           4    width of step inputs; 2**STEP_W-1 < min(X_MAX,Y_MAX)
//  VSYNC_ACTIVE_LOW 1    1: vsync asserted = 0; 0: vsync asserted = 1
// PORTS
//  clk         in   1   pixel clock (25 MHz domain), rising edge
//  rst         in   1   synchronous, active-high reset
//  vsync       in   1   vsync from sync generator, already in the clk domain
//  enable      in   1   1 = move on each frame tick, 0 = hold position
//  step_x      in   STEP_W  pixels moved per frame in x
//  step_y      in   STEP_W  lines moved per frame in y
//  box_x       out  10  registered box left edge
//  box_y       out  10  registered box top edge
//  frame_tick  out  1   1-cycle pulse, one per frame
//  bounce_x    out  1   1-cycle pulse with frame_tick when x reverses
//  bounce_y    out  1   1-cycle pulse with frame_tick when y reverses
//  bounce_cnt  out  16  bounce count; port exists only with BOX_MOTION_BOUNCE_CNT_EN
// BEHAVIOUR
//  Reset values
//  - box_x=X_INIT, box_y=Y_INIT; dir_x=INC, dir_y=INC.
//  - frame_tick=bounce_x=bounce_y=0; bounce_cnt=0.
//  - vs_q is reset to the asserted level, so no spurious tick if vsync is asserted at reset release.
//  Edge detect
//  - vs_q is vsync registered once.
//  - edge = (vsync asserted) & (vs_q deasserted), detected in cycle N.
//  - step_x, step_y and enable are sampled in cycle N.
//  - frame_tick, bounce_* and the new box_x/box_y are all visible in cycle N+1. Latency is 1 clk.
//  Per-axis FSM (x shown; y is identical with Y_MAX)
//  - States: INC, DEC. Arithmetic is done 11 bits wide; no overflow is possible.
//  - INC: if x+step >= X_MAX then x=X_MAX, go to DEC, bounce_x=1; else x=x+step.
//  - DEC: if step >= x then x=0, go to INC, bounce_x=1; else x=x-step.
//  - Landing exactly on an edge counts as a bounce (clamp and reverse in the same tick).
//  - step=0: position, direction and bounce are all unchanged, even when sitting at an edge.
//  Other rules
//  - enable=0 at edge: frame_tick still pulses; positions and directions hold; bounce_*=0.
//  - Both axes bounce in the same tick (corner): both pulses are asserted together.
//  - Outputs are stable for the whole frame between ticks.
//  - rst mid-frame: all state returns to reset values at the next edge; the next tick needs a fresh vsync edge.
// CONFIGURATION
//  `BOX_MOTION_BOUNCE_CNT_EN defined
//  - Adds the bounce_cnt port.
//  - +1 on every frame_tick cycle where bounce_x|bounce_y; a corner hit counts once.
//  - Wraps 0xFFFF->0x0000. Synchronous reset clears it.
//  Not defined
//  - The bounce_cnt port and counter are absent. All other behaviour is identical.
// TESTING
//  1 Defaults, enable=1, step_x=4, step_y=2, 3 vsync frames -> box=(12,6), 3 ticks, no bounce.
//  2 X_INIT=572, step_x=8 -> tick1 x=576, bounce_x=1; tick2 x=568, bounce_x=0.
//  3 x=3 in DEC, step_x=4 -> next tick x=0, bounce_x=1, dir INC; following tick x=4.
//  4 enable=0 for 5 frames -> 5 frame_tick pulses, box_x/box_y unchanged, no bounce pulses.
//  5 rst held while vsync asserted, then released -> no tick until the next deasserted->asserted edge; box=(X_INIT,Y_INIT).
//  6 Macro on: corner hit (x,y both clamp in one tick) -> bounce_cnt +1 only; preload 0xFFFF -> next bounce gives 0.

Source files
------------

// File: rtl/box_motion_ctrl.sv
// Per-frame box origin generator: moves (box_x, box_y) once per vsync assertion and bounces at the raster edges.
// Optional bounce counter port is enabled with `BOX_MOTION_BOUNCE_CNT_EN.
module box_motion_ctrl #(
  parameter int H_RES            = 640,
  parameter int V_RES            = 480,
  parameter int BOX_W            = 64,
  parameter int BOX_H            = 48,
  parameter int X_INIT           = 0,
  parameter int Y_INIT           = 0,
  parameter int STEP_W           = 4,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              enable,
  input  logic [STEP_W-1:0] step_x,
  input  logic [STEP_W-1:0] step_y,
  output logic [9:0]        box_x,
  output logic [9:0]        box_y,
  output logic              frame_tick,
  output logic              bounce_x,
  output logic              bounce_y
`ifdef BOX_MOTION_BOUNCE_CNT_EN
  ,
  output logic [15:0]       bounce_cnt
`endif
);

  localparam logic [9:0] X_MAX = 10'(H_RES - BOX_W);
  localparam logic [9:0] Y_MAX = 10'(V_RES - BOX_H);
  localparam logic       VS_ON = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       bounce;
  } axis_t;

  // One axis move: clamp and reverse at either edge, a zero step never moves or bounces.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic [9:0] step,
                                      input dir_e dir, input logic [9:0] lim);
    axis_t      r;
    logic [10:0] sum;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    sum      = {1'b0, pos} + {1'b0, step};
    if (step != 10'd0) begin
      case (dir)
        DIR_INC: begin
          if (sum >= {1'b0, lim}) begin
            r.pos    = lim;
            r.dir    = DIR_DEC;
            r.bounce = 1'b1;
          end else begin
            r.pos = sum[9:0];
          end
        end
        DIR_DEC: begin
          if (step >= pos) begin
            r.pos    = 10'd0;
            r.dir    = DIR_INC;
            r.bounce = 1'b1;
          end else begin
            r.pos = pos - step;
          end
        end
        default: begin
          r.pos    = pos;
          r.dir    = dir;
          r.bounce = 1'b0;
        end
      endcase
    end else begin
      r.pos    = pos;
      r.dir    = dir;
      r.bounce = 1'b0;
    end
    return r;
  endfunction

  logic       vs_q;
  logic       edge_s;
  logic [9:0] x_q, x_d, y_q, y_d;
  dir_e       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       tick_q, tick_d;
  logic       bx_q, bx_d, by_q, by_d;
  axis_t      ax_s, ay_s;
`ifdef BOX_MOTION_BOUNCE_CNT_EN
  logic [15:0] bounce_cnt_q, bounce_cnt_d;
`endif

  assign edge_s = (vsync == VS_ON) && (vs_q != VS_ON);

  // Next-state: positions/directions only change on an enabled frame edge.
  always_comb begin
    ax_s    = axis_step(x_q, 10'(step_x), dir_x_q, X_MAX);
    ay_s    = axis_step(y_q, 10'(step_y), dir_y_q, Y_MAX);
    tick_d  = edge_s;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    bx_d    = 1'b0;
    by_d    = 1'b0;
    if (edge_s && enable) begin
      x_d     = ax_s.pos;
      y_d     = ay_s.pos;
      dir_x_d = ax_s.dir;
      dir_y_d = ay_s.dir;
      bx_d    = ax_s.bounce;
      by_d    = ay_s.bounce;
    end else begin
      x_d     = x_q;
      y_d     = y_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      bx_d    = 1'b0;
      by_d    = 1'b0;
    end
`ifdef BOX_MOTION_BOUNCE_CNT_EN
    if (bx_d || by_d) begin
      bounce_cnt_d = bounce_cnt_q + 16'd1;
    end else begin
      bounce_cnt_d = bounce_cnt_q;
    end
`endif
  end

  // State and registered outputs; vs_q resets to the asserted level to suppress a tick at release.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q    <= VS_ON;
      x_q     <= 10'(X_INIT);
      y_q     <= 10'(Y_INIT);
      dir_x_q <= DIR_INC;
      dir_y_q <= DIR_INC;
      tick_q  <= 1'b0;
      bx_q    <= 1'b0;
      by_q    <= 1'b0;
`ifdef BOX_MOTION_BOUNCE_CNT_EN
      bounce_cnt_q <= 16'd0;
`endif
    end else begin
      vs_q    <= vsync;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      tick_q  <= tick_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
`ifdef BOX_MOTION_BOUNCE_CNT_EN
      bounce_cnt_q <= bounce_cnt_d;
`endif
    end
  end

  assign box_x      = x_q;
  assign box_y      = y_q;
  assign frame_tick = tick_q;
  assign bounce_x   = bx_q;
  assign bounce_y   = by_q;
`ifdef BOX_MOTION_BOUNCE_CNT_EN
  assign bounce_cnt = bounce_cnt_q;
`endif

endmodule
